// File: rtl/mem_ctrl.sv
// mem_ctrl: single-outstanding CPU-to-SRAM controller with request/ack handshake.
// Out-of-range addresses complete with err and never write the SRAM.
module mem_ctrl #(
    parameter int ADDR_LIMIT = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        wr,
    input  logic [7:0]  addr,
    input  logic [15:0] wdata,
    output logic        ready,
    output logic        ack,
    output logic        err,
    output logic [15:0] rdata,
    output logic [15:0] txn_cnt,
    output logic [7:0]  sram_addr,
    output logic [15:0] sram_din,
    output logic        sram_we,
    input  logic [15:0] sram_dout
);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        DONE
    } state_t;

    localparam logic [8:0] LIMIT = 9'(ADDR_LIMIT);

    state_t      state_q, state_d;
    logic        err_flag_q, err_flag_d;
    logic [7:0]  sram_addr_q, sram_addr_d;
    logic [15:0] sram_din_q, sram_din_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] txn_cnt_q, txn_cnt_d;
    logic        ready_q, ready_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        sram_we_q, sram_we_d;
    logic        addr_oor;

    // Widened compare so ADDR_LIMIT values up to 256 behave sensibly.
    assign addr_oor = {1'b0, addr} >= LIMIT;

    always_comb begin
        state_d     = state_q;
        err_flag_d  = err_flag_q;
        sram_addr_d = sram_addr_q;
        sram_din_d  = sram_din_q;
        rdata_d     = rdata_q;
        txn_cnt_d   = txn_cnt_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    sram_addr_d = addr;
                    sram_din_d  = wdata;
                    err_flag_d  = addr_oor;
                    if (addr_oor) begin
                        state_d = DONE;
                    end else if (wr) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            WR: begin
                state_d = DONE;
            end
            RD: begin
                rdata_d = sram_dout;
                state_d = DONE;
            end
            DONE: begin
                txn_cnt_d = txn_cnt_q + 16'd1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next-state decode so they align with state_q.
        ready_d   = (state_d == IDLE);
        sram_we_d = (state_d == WR);
        ack_d     = (state_d == DONE);
        err_d     = (state_d == DONE) && err_flag_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            err_flag_q  <= 1'b0;
            sram_addr_q <= '0;
            sram_din_q  <= '0;
            rdata_q     <= '0;
            txn_cnt_q   <= '0;
            ready_q     <= 1'b1;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            sram_we_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_flag_q  <= err_flag_d;
            sram_addr_q <= sram_addr_d;
            sram_din_q  <= sram_din_d;
            rdata_q     <= rdata_d;
            txn_cnt_q   <= txn_cnt_d;
            ready_q     <= ready_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            sram_we_q   <= sram_we_d;
        end
    end

    assign ready     = ready_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign sram_we   = sram_we_q;
    assign rdata     = rdata_q;
    assign txn_cnt   = txn_cnt_q;
    assign sram_addr = sram_addr_q;
    assign sram_din  = sram_din_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: attached SRAM model, schedule-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_mem_ctrl;

    localparam int LIMIT = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        ready;
    logic        ack;
    logic        err;
    logic [15:0] rdata;
    logic [15:0] txn_cnt;
    logic [7:0]  sram_addr;
    logic [15:0] sram_din;
    logic        sram_we;
    logic [15:0] sram_dout;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem     [256];
    logic [15:0] ref_mem [256];

    // Reference model: each accepted request is turned into absolute cycle numbers
    // for its write strobe, its ack, and the return of ready.
    int          e;
    int          we_cyc;
    int          ack_cyc;
    int          free_from;
    logic        m_err;
    logic        m_rd;
    logic [7:0]  m_addr;
    logic [15:0] m_din;
    logic [15:0] m_rdata;
    logic [15:0] m_txn;

    mem_ctrl #(.ADDR_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .txn_cnt   (txn_cnt),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_we   (sram_we),
        .sram_dout (sram_dout)
    );

    always #5 clk = ~clk;

    assign sram_dout = mem[sram_addr];

    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_din;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        we_cyc    = -10;
        ack_cyc   = -10;
        free_from = -1000;
        m_err     = 1'b0;
        m_rd      = 1'b0;
        m_addr    = '0;
        m_din     = '0;
        m_rdata   = '0;
        m_txn     = '0;
    endtask

    // Compare process: advance the model by one edge, then check every output.
    initial begin
        e = 0;
        model_reset();
        forever begin
            @(posedge clk);
            #1;
            e++;
            if (!rst_n) begin
                model_reset();
            end else begin
                if (e == we_cyc + 1) ref_mem[m_addr] = m_din;
                if (e == ack_cyc && m_rd) m_rdata = ref_mem[m_addr];
                if (e == ack_cyc + 1) m_txn = m_txn + 16'd1;
                if ((e - 1) >= free_from && req) begin
                    m_addr = addr;
                    m_din  = wdata;
                    if (int'(addr) >= LIMIT) begin
                        m_err     = 1'b1;
                        m_rd      = 1'b0;
                        we_cyc    = -10;
                        ack_cyc   = e;
                        free_from = e + 1;
                    end else begin
                        m_err     = 1'b0;
                        m_rd      = !wr;
                        we_cyc    = wr ? e : -10;
                        ack_cyc   = e + 1;
                        free_from = e + 2;
                    end
                end
            end
            chk("ready",     ready,     (e >= free_from));
            chk("ack",       ack,       (e == ack_cyc));
            chk("err",       err,       (e == ack_cyc) && m_err);
            chk("sram_we",   sram_we,   (e == we_cyc));
            chk("rdata",     rdata,     m_rdata);
            chk("txn_cnt",   txn_cnt,   m_txn);
            chk("sram_addr", sram_addr, m_addr);
            chk("sram_din",  sram_din,  m_din);
        end
    end

    task automatic issue(input logic w, input logic [7:0] a, input logic [15:0] d);
        int n;
        n = 0;
        @(negedge clk);
        req = 1'b1; wr = w; addr = a; wdata = d;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int lat, output logic a_err, output logic [15:0] rd,
                            output int we_n, output logic [7:0] we_a, output logic [15:0] we_d);
        lat = 0; a_err = 1'b0; rd = '0; we_n = 0; we_a = '0; we_d = '0;
        while (lat < 6) begin
            @(negedge clk);
            req = 1'b0;
            lat++;
            if (sram_we) begin
                we_n++;
                we_a = sram_addr;
                we_d = sram_din;
            end
            if (ack) begin
                a_err = err;
                rd    = rdata;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          we_n;
        int          n;
        int          k;
        int          acc [3];
        int          r;
        logic        a_err;
        logic [15:0] a_rd;
        logic [7:0]  we_a;
        logic [15:0] we_d;
        logic [7:0]  we_q [$];
        logic        saw_ack;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'(i * 257);
            ref_mem[i] = 16'(i * 257);
        end
        rst_n = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_ack", ack, 0);
        chk("rst_we", sram_we, 0);
        chk("rst_txn", txn_cnt, 0);
        rst_n = 1'b1;

        // Write 0x1234 to 0x05
        issue(1'b1, 8'h05, 16'h1234);
        wait_ack(lat, a_err, a_rd, we_n, we_a, we_d);
        chk("w5_latency", lat, 2);
        chk("w5_err", a_err, 0);
        chk("w5_we_pulses", we_n, 1);
        chk("w5_we_addr", we_a, 8'h05);
        chk("w5_we_data", we_d, 16'h1234);
        @(negedge clk);
        chk("w5_ready", ready, 1);
        chk("w5_txn", txn_cnt, 1);

        // Read back 0x05
        issue(1'b0, 8'h05, 16'h0000);
        wait_ack(lat, a_err, a_rd, we_n, we_a, we_d);
        chk("r5_latency", lat, 2);
        chk("r5_err", a_err, 0);
        chk("r5_rdata", a_rd, 16'h1234);
        chk("r5_we_pulses", we_n, 0);

        // Out-of-range read
        issue(1'b0, 8'h80, 16'h0000);
        wait_ack(lat, a_err, a_rd, we_n, we_a, we_d);
        chk("oor_latency", lat, 1);
        chk("oor_err", a_err, 1);
        chk("oor_rdata", a_rd, 16'h1234);
        chk("oor_we_pulses", we_n, 0);
        @(negedge clk);
        chk("oor_ready", ready, 1);
        chk("oor_txn", txn_cnt, 3);

        // Reset during WR
        issue(1'b1, 8'h07, 16'hDEAD);
        chk("mid_we_before", sram_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_we", sram_we, 0);
        chk("mid_ack", ack, 0);
        chk("mid_ready", ready, 1);
        chk("mid_err", err, 0);
        chk("mid_txn", txn_cnt, 0);
        chk("mid_rdata", rdata, 0);
        chk("mid_addr", sram_addr, 0);
        chk("mid_din", sram_din, 0);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("mid_mem7", mem[7], 16'h0707);

        // Held req across three writes, starting at the first edge after release
        rst_n = 1'b1;
        req = 1'b1; wr = 1'b1; addr = 8'h00; wdata = 16'hA000;
        n = 0; k = 0; saw_ack = 1'b0;
        while (n < 3 && k < 30) begin
            if (ready) begin
                acc[n] = k;
                n++;
                @(negedge clk);
                k++;
                if (n < 3) begin
                    addr  = 8'(n);
                    wdata = 16'hA000 + 16'(n);
                end else begin
                    req = 1'b0;
                end
            end else begin
                @(negedge clk);
                k++;
            end
            if (sram_we) we_q.push_back(sram_addr);
        end
        chk("held_accepts", n, 3);
        chk("held_first", acc[0], 0);
        chk("held_gap1", acc[1] - acc[0], 3);
        chk("held_gap2", acc[2] - acc[1], 3);
        chk("held_we_count", we_q.size(), 3);
        for (int i = 0; i < 3 && i < we_q.size(); i++) chk("held_we_addr", we_q[i], i);
        @(negedge clk);
        @(negedge clk);
        chk("held_ready", ready, 1);
        chk("held_txn", txn_cnt, 3);

        // Randomized traffic with occasional asynchronous resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req   = ($urandom_range(0, 99) < 60);
            wr    = 1'($urandom_range(0, 1));
            wdata = 16'($urandom);
            r     = $urandom_range(0, 9);
            if (r == 0)      addr = 8'($urandom_range(128, 255));
            else if (r == 1) addr = ($urandom_range(0, 1) == 1) ? 8'd127 : 8'd128;
            else if (r == 2) addr = 8'($urandom_range(0, 127));
            else             addr = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) begin
                #2;
                rst_n = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        // Counter wrap
        req = 1'b0;
        n = 0;
        @(negedge clk);
        while (!ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_idle", ready, 1);
        force dut.txn_cnt_q = 16'hFFFF;
        m_txn = 16'hFFFF;
        @(negedge clk);
        release dut.txn_cnt_q;
        chk("wrap_pre", txn_cnt, 16'hFFFF);
        issue(1'b0, 8'h05, 16'h0000);
        wait_ack(lat, a_err, a_rd, we_n, we_a, we_d);
        chk("wrap_latency", lat, 2);
        chk("wrap_err", a_err, 0);
        @(negedge clk);
        chk("wrap_txn", txn_cnt, 16'h0000);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have one parameter: ADDR_LIMIT, default 128, the number of valid SRAM words; legal addresses are 0 to ADDR_LIMIT-1.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 The ports SHALL be, with clock and reset first:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  1  CPU access request
- wr  in  1  1 = write, 0 = read; sampled with req
- addr  in  8  CPU word address
- wdata  in  16  CPU write data
- ready  out  1  controller is idle and can accept req
- ack  out  1  one-cycle transaction-complete pulse
- err  out  1  completed transaction had an out-of-range address; valid while ack = 1
- rdata  out  16  read result
- txn_cnt  out  16  count of completed transactions
- sram_addr  out  8  SRAM address
- sram_din  out  16  SRAM write data
- sram_we  out  1  SRAM write enable
- sram_dout  in  16  SRAM read data (combinational from sram_addr)

Function
REQ-004 The FSM SHALL have four states: IDLE, WR, RD, DONE; ERR SHALL be a flag, not a state.
REQ-005 ready SHALL be 1 only in IDLE; sram_we SHALL be 1 only in WR; ack SHALL be 1 only in DONE.
REQ-006 In IDLE, at a rising edge with req=1, the block SHALL latch addr into sram_addr and wdata into sram_din, and latch wr.
- If addr >= ADDR_LIMIT: set the error flag and go to DONE.
- Otherwise: clear the error flag and go to WR if wr=1, else to RD.
REQ-007 In IDLE with req=0, the state and all latched registers SHALL hold.
REQ-008 WR SHALL last exactly one cycle, with sram_we=1 and sram_addr/sram_din stable, then go to DONE.
REQ-009 RD SHALL last exactly one cycle, with sram_we=0; at the closing edge, rdata SHALL be loaded from sram_dout; the next state SHALL be DONE.
REQ-010 DONE SHALL last exactly one cycle: ack=1, err=error flag, txn_cnt increments by 1; the next state SHALL be IDLE.
REQ-011 Latency SHALL be as follows, counting the accepting edge as edge 0:
- ack is high during the second cycle after edge 0 for WR/RD.
- ack is high during the first cycle after edge 0 for out-of-range requests.
- ready returns one cycle after ack.
REQ-012 Throughput SHALL be at most one transaction per 3 cycles (in-range) or 2 cycles (out-of-range).
REQ-013 req asserted while ready=0 SHALL be ignored, with no queuing; the CPU SHALL hold req until it observes ready=1.
REQ-014 rdata SHALL change only at the end of RD; writes and errored transactions SHALL leave it unchanged.
REQ-015 An out-of-range transaction SHALL never assert sram_we; sram_addr may carry the illegal value.
REQ-016 err SHALL be 0 whenever ack=0.
REQ-017 txn_cnt SHALL be 16-bit unsigned, counting both successful and errored transactions, and SHALL wrap from 0xFFFF to 0x0000.
REQ-018 sram_we SHALL be driven directly from a state decode (glitch-free registered state) and never from combinational CPU inputs.

Reset
REQ-019 While rst_n=0, regardless of clk, the outputs SHALL be: state=IDLE, ready=1, ack=0, err=0, sram_we=0, rdata=0, txn_cnt=0, sram_addr=0, sram_din=0.
REQ-020 If rst_n asserts mid-transaction (WR/RD/DONE), sram_we SHALL drop immediately, no ack SHALL be issued, the transaction SHALL be discarded, and txn_cnt SHALL be 0.
REQ-021 After rst_n deasserts, the first rising edge SHALL be able to accept a req.

Verification
REQ-022 Write 0x1234 to addr 0x05: sram_we=1 for exactly one cycle with sram_addr=0x05, sram_din=0x1234; ack two cycles after accept; err=0; txn_cnt=1.
REQ-023 Read addr 0x05 after REQ-022 (with the SRAM model attached): rdata=0x1234 when ack=1; err=0; sram_we stays 0 throughout.
REQ-024 Read addr 0x80 with ADDR_LIMIT=128: no sram_we; ack one cycle after accept with err=1; rdata keeps its prior value 0x1234.
REQ-025 Hold req=1 continuously across three writes to addrs 0x00, 0x01, 0x02: accepts occur exactly every 3 cycles; each sram_we pulse carries the correct address; txn_cnt=3.
REQ-026 Assert rst_n=0 during WR: sram_we drops before the next edge; no ack; all REQ-019 values hold; the first post-reset req is accepted normally.
REQ-027 Preload txn_cnt to 0xFFFF (via 65535 transactions, or a force in simulation) then complete one read: txn_cnt=0x0000.
